// File: rtl/vga_pkg.sv
// VGA timing defaults and the sync bundle shared
// between the timing generator and pattern stages.
package vga_pkg;

  localparam int CLK_DIV_D    = 4;
  localparam int H_DISP_D     = 640;
  localparam int H_FP_D       = 16;
  localparam int H_SYNC_D     = 96;
  localparam int H_BP_D       = 48;
  localparam int V_DISP_D     = 480;
  localparam int V_FP_D       = 10;
  localparam int V_SYNC_D     = 2;
  localparam int V_BP_D       = 33;
  localparam int SYNC_DELAY_D = 2;
  localparam int CW           = 11;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } vga_sync_t;

  function automatic vga_sync_t sync_idle(
    input logic pol
  );
    vga_sync_t s;
    s.hsync    = ~pol;
    s.vsync    = ~pol;
    s.video_on = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Mod-CLK_DIV divider producing a registered
// one-clk pixel strobe.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          last;

  assign last = (div == DMAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div    <= '0;
      p_tick <= 1'b0;
    end else begin
      p_tick <= last;
      div    <= last ? '0 : div + DW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel x/y counters, sync and
// blanking, plus a short delay line for RGB alignment.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_D,
  parameter int H_DISP     = H_DISP_D,
  parameter int H_FP       = H_FP_D,
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BP       = H_BP_D,
  parameter int V_DISP     = V_DISP_D,
  parameter int V_FP       = V_FP_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BP       = V_BP_D,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = SYNC_DELAY_D
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          p_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          frame_start,
  output logic          hsync_d,
  output logic          vsync_d,
  output logic          video_on_d
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] HMAX  = CW'(H_TOT - 1);
  localparam logic [CW-1:0] VMAX  = CW'(V_TOT - 1);
  localparam logic [CW-1:0] HD    = CW'(H_DISP);
  localparam logic [CW-1:0] VD    = CW'(V_DISP);
  localparam logic [CW-1:0] HS_LO = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_HI = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_LO = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_HI = CW'(V_DISP + V_FP + V_SYNC - 1);

  if (H_TOT > 2047 || V_TOT > 2047) begin : g_bad_tot
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2047");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_dly
    $error("vga_timing_gen: SYNC_DELAY must be 0..4");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic          tick;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_wrap;
  logic          v_wrap;
  vga_sync_t     sync_nxt;
  vga_sync_t     sync_q;
  vga_sync_t     sync_d;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .p_tick (tick)
  );

  always_comb begin
    h_wrap = (h_cnt == HMAX);
    v_wrap = (v_cnt == VMAX);
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    if (tick) begin
      h_nxt = h_wrap ? '0 : h_cnt + CW'(1);
      if (h_wrap) begin
        v_nxt = v_wrap ? '0 : v_cnt + CW'(1);
      end
    end
  end

  // Decode from the next count so sync/blank land with x/y.
  always_comb begin
    sync_nxt.hsync = (h_nxt >= HS_LO && h_nxt <= HS_HI)
                   ? SYNC_POL : ~SYNC_POL;
    sync_nxt.vsync = (v_nxt >= VS_LO && v_nxt <= VS_HI)
                   ? SYNC_POL : ~SYNC_POL;
    sync_nxt.video_on = (h_nxt < HD) && (v_nxt < VD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      sync_q      <= sync_idle(SYNC_POL);
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      sync_q      <= sync_nxt;
      frame_start <= tick && h_wrap && v_wrap;
    end
  end

  if (SYNC_DELAY == 0) begin : g_nodly
    assign sync_d = sync_q;
  end else begin : g_dly
    vga_sync_t pipe [SYNC_DELAY];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < SYNC_DELAY; i++) begin
          pipe[i] <= sync_idle(SYNC_POL);
        end
      end else begin
        pipe[0] <= sync_q;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign sync_d = pipe[SYNC_DELAY-1];
  end

  assign p_tick     = tick;
  assign x          = h_cnt;
  assign y          = v_cnt;
  assign hsync      = sync_q.hsync;
  assign vsync      = sync_q.vsync;
  assign video_on   = sync_q.video_on;
  assign hsync_d    = sync_d.hsync;
  assign vsync_d    = sync_d.vsync;
  assign video_on_d = sync_d.video_on;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-parameter and default
// instances checked every clk against an arithmetic model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_pt, s_hs, s_vs, s_von, s_fs, s_hsd, s_vsd, s_vond;
  logic [10:0] s_x, s_y;
  logic        d_pt, d_hs, d_vs, d_von, d_fs, d_hsd, d_vsd, d_vond;
  logic [10:0] d_x, d_y;

  vga_timing_gen #(
    .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .SYNC_DELAY(2)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .p_tick(s_pt),
    .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_von), .frame_start(s_fs),
    .hsync_d(s_hsd), .vsync_d(s_vsd), .video_on_d(s_vond)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .reset_n(reset_n), .p_tick(d_pt),
    .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
    .video_on(d_von), .frame_start(d_fs),
    .hsync_d(d_hsd), .vsync_d(d_vsd), .video_on_d(d_vond)
  );

  // clk edges since reset release
  int n;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) n <= 0;
    else n <= n + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s n=%0d actual=%0h required=%0h",
                  nm, n, act, exp);
  endtask

  // {p_tick, x, y, hsync, vsync, video_on, frame_start}
  function automatic logic [26:0] base(
    int k, int c, int hd, int hf, int hs, int hb,
    int vd, int vf, int vs, int vb);
    int ht, vt, pix, px, py;
    logic pt, hsy, vsy, von, fs;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    if (k <= 0) return {1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    pt  = (k % c) == 0;
    pix = (k - 1) / c;
    px  = pix % ht;
    py  = (pix / ht) % vt;
    hsy = !(px >= hd + hf && px < hd + hf + hs);
    vsy = !(py >= vd + vf && py < vd + vf + vs);
    von = (px < hd) && (py < vd);
    fs  = (k > 1) && ((k - 1) % c == 0) && (pix % (ht * vt) == 0);
    return {pt, 11'(px), 11'(py), hsy, vsy, von, fs};
  endfunction

  function automatic logic [29:0] ref_vec(
    int k, int c, int hd, int hf, int hs, int hb,
    int vd, int vf, int vs, int vb, int d);
    logic [26:0] a, b;
    a = base(k, c, hd, hf, hs, hb, vd, vf, vs, vb);
    b = base(k - d, c, hd, hf, hs, hb, vd, vf, vs, vb);
    return {a, b[3:1]};
  endfunction

  bit first_run = 1'b1;
  int s_von_cnt = 0, s_hs_cnt = 0, s_vs_cnt = 0, s_fs_cnt = 0;
  int d_hs_cnt = 0;

  always @(negedge clk) begin
    chk("small_cycle",
        {2'b0, s_pt, s_x, s_y, s_hs, s_vs, s_von, s_fs,
         s_hsd, s_vsd, s_vond},
        {2'b0, ref_vec(n, 2, 8, 2, 3, 3, 4, 1, 2, 1, 2)});
    chk("dflt_cycle",
        {2'b0, d_pt, d_x, d_y, d_hs, d_vs, d_von, d_fs,
         d_hsd, d_vsd, d_vond},
        {2'b0, ref_vec(n, 4, 640, 16, 96, 48,
                       480, 10, 2, 33, 2)});
    if (first_run && reset_n && n >= 1 && n <= 256) begin
      s_von_cnt += int'(s_von);
      s_hs_cnt  += int'(!s_hs);
      s_vs_cnt  += int'(!s_vs);
    end
    if (first_run && reset_n && n >= 1 && n <= 600)
      s_fs_cnt += int'(s_fs);
    if (first_run && reset_n && n >= 1 && n <= 3200)
      d_hs_cnt += int'(!d_hs);
  end

  task automatic wait_n(input int k);
    int g = 0;
    while (n < k && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("wait_bound", n, k);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", s_x, 0);
    chk("rst_von", s_von, 0);
    chk("rst_hs", s_hs, 1);
    chk("rst_pt", s_pt, 0);
    reset_n = 1'b1;

    wait_n(1);   chk("pt_n1", s_pt, 0);
    wait_n(2);   chk("pt_n2", s_pt, 1);
                 chk("x_n2", s_x, 0);
    wait_n(3);   chk("x_n3", s_x, 1);
    wait_n(15);  chk("von_x7", s_von, 1);
    wait_n(17);  chk("von_x8", s_von, 0);
    wait_n(19);  chk("hs_x9", s_hs, 1);
    wait_n(21);  chk("hs_x10", s_hs, 0);
                 chk("hsd_x10", s_hsd, 1);
    wait_n(23);  chk("hsd_x10_dly", s_hsd, 0);
    wait_n(27);  chk("hs_x13", s_hs, 1);
    wait_n(31);  chk("xy_15_0", {s_x, s_y}, {11'd15, 11'd0});
    wait_n(33);  chk("xy_0_1", {s_x, s_y}, {11'd0, 11'd1});
    wait_n(159); chk("vs_y4", s_vs, 1);
    wait_n(161); chk("vs_y5", s_vs, 0);
    wait_n(256); chk("fs_n256", s_fs, 0);
    wait_n(257); chk("fs_n257", s_fs, 1);
                 chk("xy_wrap", {s_x, s_y}, 22'd0);
    wait_n(258); chk("fs_n258", s_fs, 0);
    wait_n(513); chk("fs_n513", s_fs, 1);

    wait_n(3201);
    first_run = 1'b0;
    chk("s_von_frame", s_von_cnt, 64);
    chk("s_hs_frame", s_hs_cnt, 48);
    chk("s_vs_frame", s_vs_cnt, 64);
    chk("s_fs_count", s_fs_cnt, 2);
    chk("d_hs_line", d_hs_cnt, 384);

    wait_n(6771);
    chk("mid_xy", {s_x, s_y}, {11'd9, 11'd3});
    chk("mid_dvon", d_von, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_xy", {s_x, s_y}, 22'd0);
    chk("arst_dx", d_x, 0);
    chk("arst_dvon", d_von, 0);
    chk("arst_hs", {s_hs, s_vs, s_hsd, s_vsd}, 4'hf);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_n(2);   chk("rs_pt", s_pt, 1);
    wait_n(3);   chk("rs_x", s_x, 1);
    wait_n(600);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
